branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-side next-PC producer and execute-side resolution checker for the PC register.
- Combinationally turns F_pc into F_BP_target_pc using a direct-mapped BTB with 2-bit saturating counters.
- Updates the table from resolved branches in EX.
- Generates EX_taken/EX_alt_pc, the redirect that the PC register consumes. Redirect fires only on a misprediction.

Parameters:
- PCLEN, 12, PC width in bits.
- ENTRIES, 16, BTB entries; power of two, at least 2; IDXW = log2(ENTRIES).
- IDX_LSB, 2, lowest PC bit used for the index; bits below are ignored.
- PC_INC, 4, sequential PC increment.
- STATW, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- F_pc  in  PCLEN  current fetch PC.
- F_BP_target_pc  out  PCLEN  predicted next PC (combinational).
- F_BP_taken  out  1  prediction is taken (combinational); pipelined alongside the instruction by the caller.
- EX_br_valid  in  1  valid resolved branch/jump in EX; caller gates it low for bubbles and flushed slots.
- EX_br_pc  in  PCLEN  PC of the resolved branch.
- EX_br_taken  in  1  actual direction; always 1 for jumps.
- EX_br_target  in  PCLEN  actual taken target.
- EX_pred_taken  in  1  F_BP_taken carried from fetch.
- EX_pred_target  in  PCLEN  F_BP_target_pc carried from fetch.
- EX_taken  out  1  redirect (mispredict), combinational.
- EX_alt_pc  out  PCLEN  correct PC on redirect.
- stat_branches  out  STATW  resolved-branch count.
- stat_mispredicts  out  STATW  redirect count.

Behaviour:
- Entry fields: valid, tag = pc[PCLEN-1:IDX_LSB+IDXW], target[PCLEN], ctr[2]. Index = pc[IDX_LSB+IDXW-1:IDX_LSB].
- Reset (async): all valid=0, all ctr=2'b01, targets=0, both stat counters=0. Reset asserted mid-operation discards all history immediately.
- Lookup:
  - hit = valid && tag match.
  - F_BP_taken = hit && ctr[1].
  - F_BP_target_pc = F_BP_taken ? target : F_pc + PC_INC, truncated to PCLEN (wraps, e.g. 0xFFC -> 0x000).
- Redirect (combinational, only when EX_br_valid=1):
  - EX_taken = (EX_br_taken != EX_pred_taken) || (EX_br_taken && EX_br_target != EX_pred_target).
  - EX_alt_pc = EX_br_taken ? EX_br_target : EX_br_pc + PC_INC (wraps).
  - When EX_br_valid=0: EX_taken=0 and EX_alt_pc=0.
- Update (posedge, when EX_br_valid=1), indexed by EX_br_pc:
  - Hit: ctr saturating increment if taken, else saturating decrement (11 and 00 saturate). If taken, target <= EX_br_target.
  - Miss and taken: allocate or overwrite the entry with valid=1, new tag, target, ctr=2'b10.
  - Miss and not taken: table unchanged.
- Read-during-write: a lookup in the same cycle as an update to the same index sees the pre-update contents. The new contents are visible the next cycle.
- Stats (posedge):
  - stat_branches += 1 on each EX_br_valid.
  - stat_mispredicts += 1 on each EX_taken.
  - Both saturate at all-ones.
- Holding F_pc across stall cycles needs no special handling; lookup is purely combinational.

Test Plan (PCLEN=12, ENTRIES=16, IDX_LSB=2):
1. Reset, F_pc=0x040 -> F_BP_taken=0, F_BP_target_pc=0x044; stats=0; EX_taken=0 with EX_br_valid=0.
2. Miss allocate: EX_br_valid=1, pc=0x040, taken=1, target=0x100, pred_taken=0 -> EX_taken=1, EX_alt_pc=0x100, stat_mispredicts=1. Next cycle F_pc=0x040 -> taken=1, target=0x100 (ctr=10). Same-cycle lookup of 0x040 during the update -> 0x044.
3. Alias: F_pc=0x080 (same index 0, different tag) -> miss, 0x084. Not-taken update at 0x080 -> no allocation; 0x040 entry unchanged.
4. Decay: two not-taken updates at 0x040 (first pred_taken=1, pred_target=0x100):
   - First -> EX_taken=1, EX_alt_pc=0x044, ctr 10->01.
   - Second (pred_taken=0) -> EX_taken=0, ctr 01->00.
   - Lookup afterwards -> 0x044.
5. Saturation/target change:
   - Three taken updates (pred correct, target 0x100) -> ctr saturates at 11, EX_taken=0 each time.
   - Then taken to 0x200 with pred_target=0x100 -> EX_taken=1, EX_alt_pc=0x200; next lookup -> 0x200.
6. Wrap and reset:
   - F_pc=0xFFC miss -> 0x000.
   - Assert rst mid-run -> every lookup falls back to PC+4 and stats return to 0.
   - Stat saturation with STATW=4: 20 branches -> stat_branches=15.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side next-PC predictor and execute-side resolution checker.
//
// A direct-mapped BTB holds one entry per index, and each entry has a 2-bit saturating
// direction counter. Fetch lookup is purely combinational. Resolved branches from EX
// update the table on the clock edge. A redirect (EX_taken/EX_alt_pc) is raised only
// when the fetch-time prediction was wrong.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   F_pc              current fetch PC
//   F_BP_target_pc    predicted next PC (combinational)
//   F_BP_taken        prediction is taken (combinational)
//   EX_br_valid       a resolved branch/jump is present in EX
//   EX_br_pc          PC of the resolved branch
//   EX_br_taken       actual direction
//   EX_br_target      actual taken target
//   EX_pred_taken     F_BP_taken carried down from fetch
//   EX_pred_target    F_BP_target_pc carried down from fetch
//   EX_taken          redirect on mispredict (combinational)
//   EX_alt_pc         correct PC when redirecting, 0 when EX_br_valid is low
//   stat_branches     saturating count of resolved branches
//   stat_mispredicts  saturating count of redirects
module branch_predictor #(
    parameter int unsigned PCLEN   = 12,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_LSB = 2,
    parameter int unsigned PC_INC  = 4,
    parameter int unsigned STATW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PCLEN-1:0] F_pc,
    output logic [PCLEN-1:0] F_BP_target_pc,
    output logic             F_BP_taken,
    input  logic             EX_br_valid,
    input  logic [PCLEN-1:0] EX_br_pc,
    input  logic             EX_br_taken,
    input  logic [PCLEN-1:0] EX_br_target,
    input  logic             EX_pred_taken,
    input  logic [PCLEN-1:0] EX_pred_target,
    output logic             EX_taken,
    output logic [PCLEN-1:0] EX_alt_pc,
    output logic [STATW-1:0] stat_branches,
    output logic [STATW-1:0] stat_mispredicts
);

    localparam int unsigned IDXW    = $clog2(ENTRIES);
    localparam int unsigned TAG_LSB = IDX_LSB + IDXW;
    localparam int unsigned TAGW    = PCLEN - TAG_LSB;

    logic             valid_q  [ENTRIES];
    logic [TAGW-1:0]  tag_q    [ENTRIES];
    logic [PCLEN-1:0] target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [STATW-1:0] stat_branches_q, stat_branches_d;
    logic [STATW-1:0] stat_mispredicts_q, stat_mispredicts_d;

    // Fetch lookup
    logic [IDXW-1:0] f_idx;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;

    always_comb begin
        f_idx          = F_pc[TAG_LSB-1:IDX_LSB];
        f_tag          = F_pc[PCLEN-1:TAG_LSB];
        f_hit          = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        F_BP_taken     = f_hit && ctr_q[f_idx][1];
        F_BP_target_pc = F_BP_taken ? target_q[f_idx] : F_pc + PCLEN'(PC_INC);
    end

    // Execute-side redirect
    always_comb begin
        EX_taken  = 1'b0;
        EX_alt_pc = '0;
        if (EX_br_valid) begin
            EX_taken  = (EX_br_taken != EX_pred_taken) ||
                        (EX_br_taken && (EX_br_target != EX_pred_target));
            EX_alt_pc = EX_br_taken ? EX_br_target : EX_br_pc + PCLEN'(PC_INC);
        end
    end

    // Table update
    logic [IDXW-1:0] ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic [1:0]      ctr_upd;

    always_comb begin
        ex_idx  = EX_br_pc[TAG_LSB-1:IDX_LSB];
        ex_tag  = EX_br_pc[PCLEN-1:TAG_LSB];
        ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ctr_upd = ctr_q[ex_idx];
        if (EX_br_taken && (ctr_q[ex_idx] != 2'b11)) begin
            ctr_upd = ctr_q[ex_idx] + 2'b01;
        end else if (!EX_br_taken && (ctr_q[ex_idx] != 2'b00)) begin
            ctr_upd = ctr_q[ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (EX_br_valid) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_upd;
                if (EX_br_taken) begin
                    target_q[ex_idx] <= EX_br_target;
                end
            end else if (EX_br_taken) begin
                // Miss on a taken branch: take over the slot, starting weakly taken.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= EX_br_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    // Saturating statistics
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (EX_br_valid && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + STATW'(1);
        end
        if (EX_taken && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + STATW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor. A second instance with 4-bit
// statistics shares the stimulus so counter saturation is observable quickly.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] F_pc = '0;
    logic        EX_br_valid = 1'b0;
    logic [11:0] EX_br_pc = '0;
    logic        EX_br_taken = 1'b0;
    logic [11:0] EX_br_target = '0;
    logic        EX_pred_taken = 1'b0;
    logic [11:0] EX_pred_target = '0;

    logic [11:0] F_BP_target_pc, F_BP_target_pc4;
    logic        F_BP_taken, F_BP_taken4;
    logic        EX_taken, EX_taken4;
    logic [11:0] EX_alt_pc, EX_alt_pc4;
    logic [15:0] stat_branches, stat_mispredicts;
    logic [3:0]  stat_branches4, stat_mispredicts4;

    branch_predictor #(.PCLEN(12), .ENTRIES(16), .IDX_LSB(2), .PC_INC(4), .STATW(16)) dut (
        .clk(clk), .rst(rst), .F_pc(F_pc),
        .F_BP_target_pc(F_BP_target_pc), .F_BP_taken(F_BP_taken),
        .EX_br_valid(EX_br_valid), .EX_br_pc(EX_br_pc), .EX_br_taken(EX_br_taken),
        .EX_br_target(EX_br_target), .EX_pred_taken(EX_pred_taken),
        .EX_pred_target(EX_pred_target), .EX_taken(EX_taken), .EX_alt_pc(EX_alt_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor #(.PCLEN(12), .ENTRIES(16), .IDX_LSB(2), .PC_INC(4), .STATW(4)) dut4 (
        .clk(clk), .rst(rst), .F_pc(F_pc),
        .F_BP_target_pc(F_BP_target_pc4), .F_BP_taken(F_BP_taken4),
        .EX_br_valid(EX_br_valid), .EX_br_pc(EX_br_pc), .EX_br_taken(EX_br_taken),
        .EX_br_target(EX_br_target), .EX_pred_taken(EX_pred_taken),
        .EX_pred_target(EX_pred_target), .EX_taken(EX_taken4), .EX_alt_pc(EX_alt_pc4),
        .stat_branches(stat_branches4), .stat_mispredicts(stat_mispredicts4)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arrays indexed by (pc / 4) % 16, tag = pc / 64.
    bit m_valid  [16];
    int m_tag    [16];
    int m_target [16];
    int m_ctr    [16];
    int m_nbr;
    int m_nmis;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_ctr[i]    = 1;
        end
        m_nbr  = 0;
        m_nmis = 0;
    endfunction

    function automatic void m_lookup(input int pc, output bit tk, output int tgt);
        int i = (pc / 4) % 16;
        bit hit = m_valid[i] && (m_tag[i] == pc / 64);
        tk  = hit && (m_ctr[i] >= 2);
        tgt = tk ? m_target[i] : (pc + 4) % 4096;
    endfunction

    function automatic void m_update(input int pc, input bit tk, input int tgt);
        int i = (pc / 4) % 16;
        bit hit = m_valid[i] && (m_tag[i] == pc / 64);
        if (hit) begin
            if (tk) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_target[i] = tgt;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = pc / 64;
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic drive_ex(input bit v, input int pc, input bit tk, input int tgt,
                            input bit ptk, input int ptgt);
        EX_br_valid    = v;
        EX_br_pc       = 12'(pc);
        EX_br_taken    = tk;
        EX_br_target   = 12'(tgt);
        EX_pred_taken  = ptk;
        EX_pred_target = 12'(ptgt);
    endtask

    // Check combinational outputs against the pre-edge model, clock, then check stats.
    task automatic tick();
        bit etk;
        int etgt;
        bit ered;
        int ealt;
        #1;
        m_lookup(int'(F_pc), etk, etgt);
        check("f_taken", 32'(F_BP_taken), 32'(etk));
        check("f_target", 32'(F_BP_target_pc), 32'(etgt));
        check("f_target_s4", 32'(F_BP_target_pc4), 32'(etgt));
        ered = EX_br_valid && ((EX_br_taken != EX_pred_taken) ||
                               (EX_br_taken && (EX_br_target != EX_pred_target)));
        ealt = !EX_br_valid ? 0 :
               EX_br_taken ? int'(EX_br_target) : (int'(EX_br_pc) + 4) % 4096;
        check("ex_taken", 32'(EX_taken), 32'(ered));
        check("ex_alt_pc", 32'(EX_alt_pc), 32'(ealt));
        @(posedge clk);
        if (EX_br_valid) begin
            m_nbr++;
            if (ered) m_nmis++;
            m_update(int'(EX_br_pc), EX_br_taken, int'(EX_br_target));
        end
        #1;
        check("stat_br", 32'(stat_branches), 32'(sat(m_nbr, 65535)));
        check("stat_mis", 32'(stat_mispredicts), 32'(sat(m_nmis, 65535)));
        check("stat_br_s4", 32'(stat_branches4), 32'(sat(m_nbr, 15)));
        check("stat_mis_s4", 32'(stat_mispredicts4), 32'(sat(m_nmis, 15)));
    endtask

    initial begin
        bit ptk;
        int ptgt;
        int pc;
        m_reset();
        #12 rst = 1'b0;

        // Reset state
        F_pc = 12'h040;
        drive_ex(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_taken", 32'(F_BP_taken), 0);
        check("rst_target", 32'(F_BP_target_pc), 32'h044);
        check("rst_ex_taken", 32'(EX_taken), 0);
        tick();

        // Miss allocate, same-cycle lookup sees old contents
        drive_ex(1, 'h040, 1, 'h100, 0, 0);
        tick();
        check("alloc_stat_mis", 32'(stat_mispredicts), 1);
        drive_ex(0, 0, 0, 0, 0, 0);
        #1;
        check("alloc_hit_target", 32'(F_BP_target_pc), 32'h100);
        tick();

        // Alias at same index, not-taken does not allocate
        F_pc = 12'h080;
        tick();
        drive_ex(1, 'h080, 0, 0, 0, 0);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0);
        F_pc = 12'h040;
        tick();

        // Decay to strongly not-taken
        drive_ex(1, 'h040, 0, 0, 1, 'h100);
        #1;
        check("decay_redirect", 32'(EX_taken), 1);
        check("decay_alt", 32'(EX_alt_pc), 32'h044);
        tick();
        drive_ex(1, 'h040, 0, 0, 0, 0);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0);
        tick();

        // Saturate upward, then change target
        for (int k = 0; k < 3; k++) begin
            drive_ex(1, 'h040, 1, 'h100, 1, 'h100);
            tick();
        end
        drive_ex(1, 'h040, 1, 'h200, 1, 'h100);
        tick();
        drive_ex(0, 0, 0, 0, 0, 0);
        #1;
        check("newtarget", 32'(F_BP_target_pc), 32'h200);
        tick();

        // PC wrap
        F_pc = 12'hFFC;
        #1;
        check("wrap", 32'(F_BP_target_pc), 0);
        tick();

        // Stat saturation on the narrow instance
        for (int k = 0; k < 20; k++) begin
            drive_ex(1, 'h300, 0, 0, 0, 0);
            tick();
        end
        check("stat4_sat", 32'(stat_branches4), 15);

        // Asynchronous reset mid-run drops all history
        drive_ex(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        m_reset();
        for (int k = 0; k < 3; k++) begin
            pc   = (k == 0) ? 'h040 : (k == 1) ? 'h100 : 'hFFC;
            F_pc = 12'(pc);
            #1;
            check("rst_mid_target", 32'(F_BP_target_pc), 32'((pc + 4) % 4096));
            check("rst_mid_taken", 32'(F_BP_taken), 0);
        end
        check("rst_mid_stat_br", 32'(stat_branches), 0);
        check("rst_mid_stat_mis", 32'(stat_mispredicts), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic over a small PC pool so hits, aliases and decay all occur
        for (int n = 0; n < 600; n++) begin
            F_pc = 12'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                       $urandom_range(0, 3));
            pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 1) == 1) begin
                m_lookup(pc, ptk, ptgt);
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = $urandom_range(0, 4095);
            end
            drive_ex($urandom_range(0, 3) != 0, pc, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? ptgt : $urandom_range(0, 4095), ptk, ptgt);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
